// File: rtl/axi_s_m_pkt_if.sv
// Command + AXI-Stream bundle for the packet generator.
// Latency: n/a (wires only).
// Backpressure: m_tready from the slave; cmd_ready towards the host.
// Ports: newd/din/len/inc push a command; cmd_ready/cmd_err report acceptance;
//        m_tdata/m_tvalid/m_tready/m_tlast are the stream; busy/pkt_done are status.
interface axi_s_m_pkt_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
);
  logic              newd;
  logic [DATA_W-1:0] din;
  logic [LEN_W-1:0]  len;
  logic              inc;
  logic              cmd_ready;
  logic              cmd_err;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              busy;
  logic              pkt_done;

  // Generator side.
  modport master (
    input  newd, din, len, inc, m_tready,
    output cmd_ready, cmd_err, m_tdata, m_tvalid, m_tlast, busy, pkt_done
  );

  // Host and stream-sink side.
  modport slave (
    output newd, din, len, inc, m_tready,
    input  cmd_ready, cmd_err, m_tdata, m_tvalid, m_tlast, busy, pkt_done
  );
endinterface

// File: rtl/axi_s_m_pkt.sv
// AXI-Stream packet generator: queued {din,len,inc} commands become one packet each.
// Latency: command accepted at edge N -> first beat valid after edge N+1; 1 beat/cycle.
// Backpressure: m_tready stalls with all stream outputs held; cmd_ready drops when queue full.
// Ports: m_aclk, m_reset (sync, active-high); bus (master modport) carries the
//        command push (newd/din/len/inc/cmd_ready/cmd_err), the stream (m_t*)
//        and status (busy, pkt_done).
module axi_s_m_pkt #(
  parameter int DATA_W    = 8,
  parameter int MAX_LEN   = 16,
  parameter int CMD_DEPTH = 4,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic          m_aclk,
  input  logic          m_reset,
  axi_s_m_pkt_if.master bus
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] din;
    logic [LEN_W-1:0]  len;
    logic              inc;
  } cmd_t;

  typedef enum logic {IDLE, SEND} state_t;

  // Command queue
  cmd_t             mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_q;
  logic             cmd_err_q;
  cmd_t             head;
  cmd_t             cmd_in;
  logic             len_ok, push, pop;

  // Stream datapath
  state_t            state_q, state_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [LEN_W-1:0]  beats_q, beats_d;   // beats remaining after the current one
  logic              inc_q, inc_d;
  logic              pkt_done_q, pkt_done_d;

  assign cmd_in = '{din: bus.din, len: bus.len, inc: bus.inc};
  assign head   = mem[rd_ptr_q];
  assign len_ok = (bus.len != '0) && (bus.len <= LEN_W'(MAX_LEN));
  assign push   = bus.newd && cmd_ready_q && len_ok;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge m_aclk) begin
    if (push)
      mem[wr_ptr_q] <= cmd_in;
  end

  // FSM state register
  always_ff @(posedge m_aclk) begin
    if (m_reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state, pop and next stream outputs
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    beats_d    = beats_q;
    inc_d      = inc_q;
    pop        = 1'b0;
    pkt_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop      = 1'b1;
          state_d  = SEND;
          tdata_d  = head.din;
          beats_d  = head.len - LEN_W'(1);
          inc_d    = head.inc;
          tvalid_d = 1'b1;
          tlast_d  = (head.len == LEN_W'(1));
        end
      end
      SEND: begin
        // tvalid is always high in SEND, so tready alone marks the handshake.
        if (bus.m_tready) begin
          if (beats_q == '0) begin
            state_d    = IDLE;
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            pkt_done_d = 1'b1;
          end else begin
            beats_d = beats_q - LEN_W'(1);
            if (inc_q)
              tdata_d = tdata_q + DATA_W'(1);
            tlast_d = (beats_q == LEN_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_aclk) begin
    if (m_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      cmd_err_q   <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      beats_q     <= '0;
      inc_q       <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q       <= cnt_d;
      // Registered full flag: follows the count after this edge's push/pop.
      cmd_ready_q <= (cnt_d != CNT_W'(CMD_DEPTH));
      // A push while full is ignored silently, so only accepted slots flag errors.
      cmd_err_q   <= bus.newd && cmd_ready_q && !len_ok;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      beats_q     <= beats_d;
      inc_q       <= inc_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.m_tdata   = tdata_q;
  assign bus.m_tvalid  = tvalid_q;
  assign bus.m_tlast   = tlast_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.busy      = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_axi_s_m_pkt.sv
// Directed bench for axi_s_m_pkt: hand-computed beat lists, stall and gap traces.
module tb_axi_s_m_pkt;

  logic m_aclk;
  logic m_reset;

  axi_s_m_pkt_if #(.DATA_W(8), .LEN_W(5)) bus ();

  axi_s_m_pkt #(
    .DATA_W(8), .MAX_LEN(16), .CMD_DEPTH(4), .LEN_W(5)
  ) dut (
    .m_aclk (m_aclk),
    .m_reset(m_reset),
    .bus    (bus)
  );

  initial m_aclk = 1'b0;
  always #5 m_aclk = ~m_aclk;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0]  cap_q[$];   // {tlast, tdata} of every handshake
  logic [8:0]  exp_q[$];
  logic [13:0] vtr, rtr;
  int          dn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are already settled at the negedge; record a handshake, then advance one cycle.
  task automatic tick();
    if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1)
      cap_q.push_back({bus.m_tlast, bus.m_tdata});
    @(posedge m_aclk);
    @(negedge m_aclk);
  endtask

  task automatic push_cmd(input logic [7:0] d, input logic [4:0] l, input logic i);
    bus.newd = 1'b1;
    bus.din  = d;
    bus.len  = l;
    bus.inc  = i;
    tick();
    bus.newd = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.pkt_done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, {31'd0, bus.pkt_done}, 32'd1);
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_n"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i),
          (i < cap_q.size()) ? {23'd0, cap_q[i]} : 32'hDEAD, {23'd0, exp_q[i]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] stall_exp [6];
    logic       rdy_pat   [6];

    m_reset      = 1'b1;
    bus.newd     = 1'b0;
    bus.din      = '0;
    bus.len      = '0;
    bus.inc      = 1'b0;
    bus.m_tready = 1'b0;
    @(negedge m_aclk);
    tick();
    tick();

    // Reset state
    chk("rst_tvalid",    bus.m_tvalid,  1'b0);
    chk("rst_tlast",     bus.m_tlast,   1'b0);
    chk("rst_tdata",     bus.m_tdata,   8'h00);
    chk("rst_cmd_err",   bus.cmd_err,   1'b0);
    chk("rst_pkt_done",  bus.pkt_done,  1'b0);
    chk("rst_busy",      bus.busy,      1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    m_reset = 1'b0;
    tick();

    // Single incrementing packet, latency and tlast position
    bus.m_tready = 1'b1;
    cap_q.delete();
    push_cmd(8'h10, 5'd4, 1'b1);
    chk("t1_lat_tvalid0", bus.m_tvalid, 1'b0);
    chk("t1_lat_busy",    bus.busy,     1'b1);
    tick();
    chk("t1_first_tvalid", bus.m_tvalid, 1'b1);
    chk("t1_first_tdata",  bus.m_tdata,  8'h10);
    wait_done("t1");
    exp_q = '{9'h010, 9'h011, 9'h012, 9'h113};
    check_beats("t1");
    chk("t1_busy_after",   bus.busy,     1'b0);
    chk("t1_tvalid_after", bus.m_tvalid, 1'b0);
    tick();
    chk("t1_done_pulse", bus.pkt_done, 1'b0);

    // Backpressure: constant-data packet, tready 1,0,0,1,0,1
    bus.m_tready = 1'b0;
    cap_q.delete();
    push_cmd(8'hA5, 5'd3, 1'b0);
    tick();
    chk("t2_first_tvalid", bus.m_tvalid, 1'b1);
    rdy_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    // {tvalid, tlast, tdata} after each cycle
    stall_exp = '{10'h2A5, 10'h2A5, 10'h2A5, 10'h3A5, 10'h3A5, 10'h0A5};
    for (int i = 0; i < 6; i++) begin
      bus.m_tready = rdy_pat[i];
      tick();
      chk($sformatf("t2_step%0d", i), {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, stall_exp[i]);
    end
    chk("t2_pkt_done", bus.pkt_done, 1'b1);
    exp_q = '{9'h0A5, 9'h0A5, 9'h1A5};
    check_beats("t2");

    // Queue full while one packet is stalled on the bus, then drain back-to-back
    bus.m_tready = 1'b0;
    push_cmd(8'h20, 5'd2, 1'b1);
    tick();
    chk("t3_pre_tvalid", bus.m_tvalid, 1'b1);
    push_cmd(8'h30, 5'd1, 1'b0);
    push_cmd(8'h40, 5'd2, 1'b0);
    push_cmd(8'h50, 5'd1, 1'b1);
    chk("t3_ready_3rd", bus.cmd_ready, 1'b1);
    push_cmd(8'h60, 5'd2, 1'b1);
    chk("t3_ready_4th", bus.cmd_ready, 1'b0);
    push_cmd(8'h70, 5'd1, 1'b0);
    chk("t3_err_5th",   bus.cmd_err,   1'b0);
    chk("t3_ready_5th", bus.cmd_ready, 1'b0);
    bus.m_tready = 1'b1;
    cap_q.delete();
    vtr = '0;
    rtr = '0;
    dn  = 0;
    for (int i = 0; i < 14; i++) begin
      vtr = {vtr[12:0], bus.m_tvalid};
      rtr = {rtr[12:0], bus.cmd_ready};
      if (bus.pkt_done === 1'b1) dn++;
      tick();
    end
    chk("t3_valid_trace", vtr, 14'b11010110101100);
    chk("t3_ready_trace", rtr, 14'b00011111111111);
    chk("t3_pkts", dn, 5);
    exp_q = '{9'h020, 9'h121, 9'h130, 9'h040, 9'h140, 9'h150, 9'h060, 9'h161};
    check_beats("t3");
    chk("t3_busy_end", bus.busy, 1'b0);

    // Wrap, illegal lengths, single-beat packet
    cap_q.delete();
    push_cmd(8'hFE, 5'd3, 1'b1);
    wait_done("t4w");
    exp_q = '{9'h0FE, 9'h0FF, 9'h100};
    check_beats("t4w");
    cap_q.delete();
    push_cmd(8'h11, 5'd0, 1'b1);
    chk("t4_err_len0",  bus.cmd_err, 1'b1);
    chk("t4_busy_len0", bus.busy,    1'b0);
    tick();
    chk("t4_err_clear", bus.cmd_err, 1'b0);
    push_cmd(8'h22, 5'd17, 1'b1);
    chk("t4_err_len17", bus.cmd_err, 1'b1);
    tick();
    chk("t4_err_clear2", bus.cmd_err, 1'b0);
    tick();
    tick();
    chk("t4_no_beats", cap_q.size(), 0);
    chk("t4_busy_idle", bus.busy, 1'b0);
    push_cmd(8'h77, 5'd1, 1'b0);
    wait_done("t4s");
    exp_q = '{9'h177};
    check_beats("t4s");

    // Reset in the middle of a len=8 packet with two commands queued
    bus.m_tready = 1'b0;
    push_cmd(8'h80, 5'd8, 1'b1);
    push_cmd(8'h90, 5'd2, 1'b0);
    push_cmd(8'hA0, 5'd2, 1'b0);
    cap_q.delete();
    bus.m_tready = 1'b1;
    tick();
    tick();
    exp_q = '{9'h080, 9'h081};
    check_beats("t5pre");
    chk("t5_beat3_data",  bus.m_tdata,  8'h82);
    chk("t5_beat3_valid", bus.m_tvalid, 1'b1);
    m_reset = 1'b1;
    tick();
    chk("t5_rst_tvalid",    bus.m_tvalid,  1'b0);
    chk("t5_rst_tdata",     bus.m_tdata,   8'h00);
    chk("t5_rst_busy",      bus.busy,      1'b0);
    chk("t5_rst_cmd_ready", bus.cmd_ready, 1'b1);
    m_reset = 1'b0;
    cap_q.delete();
    for (int i = 0; i < 6; i++) tick();
    chk("t5_no_beats",    cap_q.size(),  0);
    chk("t5_idle_tvalid", bus.m_tvalid,  1'b0);
    chk("t5_idle_busy",   bus.busy,      1'b0);
    chk("t5_cmd_ready",   bus.cmd_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
